// File: rtl/sequenciador_acumulador_pkg.sv
// Shared definitions for the accumulator sequencer: FSM state encoding and default widths.
package sequenciador_acumulador_pkg;

    localparam int unsigned AddrWDefault = 8;

    typedef enum logic [1:0] {
        StOcioso     = 2'd0,
        StLendo      = 2'd1,
        StEsvaziando = 2'd2,
        StFim        = 2'd3
    } state_e;

endpackage

// File: rtl/sequenciador_acumulador.sv
// Sequencer that streams a block of memory words into the accumulator, one word per cycle,
// driving the Load/Transfer strobes through a two-flop delay line behind the read enable.
module sequenciador_acumulador
    import sequenciador_acumulador_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   count_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    output logic              load_o,
    output logic              transfer_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] AddrOne = 1;
    localparam logic [ADDR_W:0]   CntOne  = 1;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remaining_q;
    logic              mem_rd_q;
    logic              load_q;
    logic              transfer_q;
    logic              busy_q;
    logic              done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StOcioso;
            addr_q      <= '0;
            remaining_q <= '0;
            mem_rd_q    <= 1'b0;
            load_q      <= 1'b0;
            transfer_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            load_q     <= mem_rd_q;
            transfer_q <= load_q;
            done_q     <= 1'b0;
            unique case (state_q)
                StOcioso: begin
                    if (start_i) begin
                        if (count_i != '0) begin
                            state_q     <= StLendo;
                            addr_q      <= base_addr_i;
                            remaining_q <= count_i - CntOne;
                            mem_rd_q    <= 1'b1;
                            busy_q      <= 1'b1;
                        end else begin
                            state_q <= StFim;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StLendo: begin
                    // remaining_q counts reads still owed after the one issued this cycle
                    if (remaining_q == '0) begin
                        state_q  <= StEsvaziando;
                        mem_rd_q <= 1'b0;
                    end else begin
                        addr_q      <= addr_q + AddrOne;
                        remaining_q <= remaining_q - CntOne;
                    end
                end
                StEsvaziando: begin
                    // Load low now means Transfer drops at this edge: last addition lands
                    if (!load_q) begin
                        state_q <= StFim;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StFim: begin
                    state_q <= StOcioso;
                end
                default: begin
                    state_q <= StOcioso;
                end
            endcase
        end
    end

    assign mem_addr_o = addr_q;
    assign mem_rd_o   = mem_rd_q;
    assign load_o     = load_q;
    assign transfer_o = transfer_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_sequenciador_acumulador.sv
// Directed bench: two sequencer instances (ADDR_W=8 and ADDR_W=4) with memory and accumulator models.
module tb_sequenciador_acumulador;

    logic clk;
    logic rst_n;

    logic       start8;
    logic [7:0] base8;
    logic [8:0] cnt8;
    logic [7:0] addr8;
    logic       rd8, ld8, tr8, busy8, done8;

    logic       start4;
    logic [3:0] base4;
    logic [4:0] cnt4;
    logic [3:0] addr4;
    logic       rd4, ld4, tr4, busy4, done4;

    logic [7:0]  mem8 [256];
    logic [7:0]  m8, b8;
    logic [15:0] acc8;
    logic [7:0]  mem4 [16];
    logic [7:0]  m4, b4;
    logic [15:0] acc4;

    int checks;
    int errors;

    sequenciador_acumulador #(.ADDR_W(8)) u_dut8 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start8),
        .base_addr_i (base8),
        .count_i     (cnt8),
        .mem_addr_o  (addr8),
        .mem_rd_o    (rd8),
        .load_o      (ld8),
        .transfer_o  (tr8),
        .busy_o      (busy8),
        .done_o      (done8)
    );

    sequenciador_acumulador #(.ADDR_W(4)) u_dut4 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start4),
        .base_addr_i (base4),
        .count_i     (cnt4),
        .mem_addr_o  (addr4),
        .mem_rd_o    (rd4),
        .load_o      (ld4),
        .transfer_o  (tr4),
        .busy_o      (busy4),
        .done_o      (done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory feeding M; accumulator: Load captures M into B, Transfer adds B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8 <= '0; b8 <= '0; acc8 <= '0;
            m4 <= '0; b4 <= '0; acc4 <= '0;
        end else begin
            if (rd8) m8 <= mem8[addr8];
            if (ld8) b8 <= m8;
            if (tr8) acc8 <= acc8 + 16'(b8);
            if (rd4) m4 <= mem4[addr4];
            if (ld4) b4 <= m4;
            if (tr4) acc4 <= acc4 + 16'(b4);
        end
    end

    // Expected {MemRd, Load, Transfer, Busy, Done} in cycle c after a Start in cycle 0 with Count=n.
    function automatic logic [4:0] exp_vec(input int c, input int n);
        logic [4:0] v;
        v = '0;
        if (n == 0) begin
            v[0] = (c == 1);
        end else begin
            v[4] = (c >= 1) && (c <= n);
            v[3] = (c >= 2) && (c <= n + 1);
            v[2] = (c >= 3) && (c <= n + 2);
            v[1] = (c >= 1) && (c <= n + 2);
            v[0] = (c == n + 3);
        end
        return v;
    endfunction

    task automatic apply_clear();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd8, ld8, tr8, busy8, done8} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs8 got %b want 00000", {rd8, ld8, tr8, busy8, done8});
        end
        checks++;
        if (addr8 !== 8'd0) begin
            errors++;
            $display("FAIL reset_addr8 got %0d want 0", addr8);
        end
        checks++;
        if ({rd4, ld4, tr4, busy4, done4, addr4} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs4 got %b want 0", {rd4, ld4, tr4, busy4, done4, addr4});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sum_four();
        logic [7:0] ea;
        apply_clear();
        for (int i = 0; i < 4; i++) mem8[4 + i] = 8'(i + 1);
        start8 = 1'b1; base8 = 8'd4; cnt8 = 9'd4;
        @(negedge clk);
        start8 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if ({rd8, ld8, tr8, busy8, done8} !== exp_vec(c, 4)) begin
                errors++;
                $display("FAIL sum4_strobes c=%0d got %b want %b", c,
                         {rd8, ld8, tr8, busy8, done8}, exp_vec(c, 4));
            end
            if (c <= 4) begin
                ea = 8'd4 + 8'(c - 1);
                checks++;
                if (addr8 !== ea) begin
                    errors++;
                    $display("FAIL sum4_addr c=%0d got %0d want %0d", c, addr8, ea);
                end
            end
            if (c == 7) begin
                checks++;
                if (acc8 !== 16'd10) begin
                    errors++;
                    $display("FAIL sum4_acc got %0d want 10", acc8);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ea;
        apply_clear();
        mem8[254] = 8'd5; mem8[255] = 8'd6; mem8[0] = 8'd7;
        start8 = 1'b1; base8 = 8'd254; cnt8 = 9'd3;
        @(negedge clk);
        start8 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            checks++;
            if ({rd8, ld8, tr8, busy8, done8} !== exp_vec(c, 3)) begin
                errors++;
                $display("FAIL wrap_strobes c=%0d got %b want %b", c,
                         {rd8, ld8, tr8, busy8, done8}, exp_vec(c, 3));
            end
            if (c <= 3) begin
                ea = 8'd254 + 8'(c - 1);
                checks++;
                if (addr8 !== ea) begin
                    errors++;
                    $display("FAIL wrap_addr c=%0d got %0d want %0d", c, addr8, ea);
                end
            end
            if (c == 6) begin
                checks++;
                if (acc8 !== 16'd18) begin
                    errors++;
                    $display("FAIL wrap_acc got %0d want 18", acc8);
                end
            end
            @(negedge clk);
        end
    endtask

    // Runs right after test_wrap without Clear, so the accumulator still holds 18.
    task automatic test_count_zero();
        start8 = 1'b1; base8 = 8'd50; cnt8 = 9'd0;
        @(negedge clk);
        start8 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({rd8, ld8, tr8, busy8, done8} !== exp_vec(c, 0)) begin
                errors++;
                $display("FAIL count0_strobes c=%0d got %b want %b", c,
                         {rd8, ld8, tr8, busy8, done8}, exp_vec(c, 0));
            end
            @(negedge clk);
        end
        checks++;
        if (acc8 !== 16'd18) begin
            errors++;
            $display("FAIL count0_acc got %0d want 18", acc8);
        end
    endtask

    task automatic test_start_while_busy();
        logic [7:0] ea;
        int         dones;
        apply_clear();
        for (int i = 0; i < 5; i++) mem8[10 + i] = 8'(i + 1);
        dones = 0;
        start8 = 1'b1; base8 = 8'd10; cnt8 = 9'd5;
        @(negedge clk);
        start8 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (done8 === 1'b1) dones++;
            checks++;
            if ({rd8, ld8, tr8, busy8, done8} !== exp_vec(c, 5)) begin
                errors++;
                $display("FAIL busy_strobes c=%0d got %b want %b", c,
                         {rd8, ld8, tr8, busy8, done8}, exp_vec(c, 5));
            end
            if (c <= 5) begin
                ea = 8'd10 + 8'(c - 1);
                checks++;
                if (addr8 !== ea) begin
                    errors++;
                    $display("FAIL busy_addr c=%0d got %0d want %0d", c, addr8, ea);
                end
            end
            if (c == 3) begin
                start8 = 1'b1; base8 = 8'd100; cnt8 = 9'd2;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL busy_done_count got %0d want 1", dones);
        end
        checks++;
        if (acc8 !== 16'd15) begin
            errors++;
            $display("FAIL busy_acc got %0d want 15", acc8);
        end
    endtask

    task automatic test_clear_mid_run();
        apply_clear();
        mem8[30] = 8'd8; mem8[31] = 8'd9;
        start8 = 1'b1; base8 = 8'd20; cnt8 = 9'd6;
        @(negedge clk);
        start8 = 1'b0;
        for (int c = 1; c <= 3; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd8, ld8, tr8, busy8, done8, addr8} !== 13'b0) begin
            errors++;
            $display("FAIL clear_async got %b want 0", {rd8, ld8, tr8, busy8, done8, addr8});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({rd8, ld8, tr8, busy8, done8} !== 5'b0) begin
            errors++;
            $display("FAIL clear_no_done got %b want 00000", {rd8, ld8, tr8, busy8, done8});
        end
        start8 = 1'b1; base8 = 8'd30; cnt8 = 9'd2;
        @(negedge clk);
        start8 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if ({rd8, ld8, tr8, busy8, done8} !== exp_vec(c, 2)) begin
                errors++;
                $display("FAIL clear_rerun c=%0d got %b want %b", c,
                         {rd8, ld8, tr8, busy8, done8}, exp_vec(c, 2));
            end
            if (c == 5) begin
                checks++;
                if (acc8 !== 16'd17) begin
                    errors++;
                    $display("FAIL clear_rerun_acc got %0d want 17", acc8);
                end
            end
            @(negedge clk);
        end
    endtask

    // Start held through FIM and the following idle cycle: only the idle-cycle sample counts.
    task automatic test_back_to_back();
        logic [4:0] ev;
        apply_clear();
        mem8[40] = 8'd9; mem8[41] = 8'd1;
        start8 = 1'b1; base8 = 8'd40; cnt8 = 9'd2;
        @(negedge clk);
        start8 = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            ev = (c <= 5) ? exp_vec(c, 2) : exp_vec(c - 6, 2);
            checks++;
            if ({rd8, ld8, tr8, busy8, done8} !== ev) begin
                errors++;
                $display("FAIL b2b_strobes c=%0d got %b want %b", c,
                         {rd8, ld8, tr8, busy8, done8}, ev);
            end
            if (c == 11) begin
                checks++;
                if (acc8 !== 16'd20) begin
                    errors++;
                    $display("FAIL b2b_acc got %0d want 20", acc8);
                end
            end
            start8 = (c == 5) || (c == 6);
            @(negedge clk);
        end
    endtask

    task automatic test_full_block();
        int seen [16];
        int bad;
        apply_clear();
        for (int i = 0; i < 16; i++) begin
            mem4[i] = 8'd1;
            seen[i] = 0;
        end
        start4 = 1'b1; base4 = 4'd0; cnt4 = 5'd16;
        @(negedge clk);
        start4 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (rd4 === 1'b1) seen[addr4] = seen[addr4] + 1;
            checks++;
            if ({rd4, ld4, tr4, busy4, done4} !== exp_vec(c, 16)) begin
                errors++;
                $display("FAIL full_strobes c=%0d got %b want %b", c,
                         {rd4, ld4, tr4, busy4, done4}, exp_vec(c, 16));
            end
            if (c == 19) begin
                checks++;
                if (acc4 !== 16'd16) begin
                    errors++;
                    $display("FAIL full_acc got %0d want 16", acc4);
                end
            end
            @(negedge clk);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (seen[i] != 1) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL full_coverage addresses_not_read_once got %0d want 0", bad);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start8 = 1'b0; base8 = '0; cnt8 = '0;
        start4 = 1'b0; base4 = '0; cnt4 = '0;
        for (int i = 0; i < 256; i++) mem8[i] = 8'd0;
        for (int i = 0; i < 16; i++) mem4[i] = 8'd0;
        test_reset();
        test_sum_four();
        test_wrap();
        test_count_zero();
        test_start_while_busy();
        test_clear_mid_run();
        test_back_to_back();
        test_full_block();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
